branch_predict_unit: RTL

// - Decode-side partner of the fetch stage. Each cycle it inspects the instruction/PC+4 pair from the IF/DE

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/branch_predict_unit_if.sv | 25 ++
 rtl/pred_queue.sv | 49 ++++
 rtl/branch_predict_unit.sv | 103 ++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the decode-side branch predictor: opcode, counter states
// and the in-flight prediction record.
package cpu_pkg;

    localparam int XLEN      = 32;
    localparam int BHT_DEPTH = 64;
    localparam int BHT_IDX_W = $clog2(BHT_DEPTH);
    localparam int Q_DEPTH   = 4;

    localparam logic [4:0] BR_OPCODE = 5'b01100;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef struct packed {
        logic                 pred;
        logic [XLEN-1:0]      target;
        logic [XLEN-1:0]      pc_inc4;
        logic [BHT_IDX_W-1:0] idx;
    } bpu_entry_t;

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch/execute-facing signal bundle of the branch predictor.
interface branch_predict_unit_if #(
    parameter int N = 32
);
    logic         if_valid;
    logic [N-1:0] if_instr;
    logic [N-1:0] if_pc_inc4;
    logic         ex_resolve;
    logic         ex_taken;
    logic         BranchTaken;
    logic         Flush;
    logic [N-1:0] LastPC;
    logic         de_stall;
    logic         q_err;

    modport master (
        output if_valid, if_instr, if_pc_inc4, ex_resolve, ex_taken,
        input  BranchTaken, Flush, LastPC, de_stall, q_err
    );

    modport slave (
        input  if_valid, if_instr, if_pc_inc4, ex_resolve, ex_taken,
        output BranchTaken, Flush, LastPC, de_stall, q_err
    );
endinterface

// File: rtl/pred_queue.sv
// In-order FIFO of outstanding predictions; clear discards everything in one cycle.
module pred_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       clear,
    input  bpu_entry_t din,
    output bpu_entry_t head,
    output logic       full,
    output logic       empty
);
    localparam int PW = $clog2(DEPTH);

    bpu_entry_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Entry storage carries no reset; only pointers and count qualify it.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/branch_predict_unit.sv
// Decode-stage branch predictor: 2-bit BHT lookup, in-order tracking of predictions,
// training on resolution and mispredict recovery toward fetch.
module branch_predict_unit
    import cpu_pkg::*;
#(
    parameter int N           = XLEN,
    parameter int BHT_ENTRIES = BHT_DEPTH,
    parameter int QDEPTH      = Q_DEPTH
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_predict_unit_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    ctr_t                bht [BHT_ENTRIES];
    logic                is_br;
    logic signed [N-1:0] off;
    logic [N-1:0]        pc;
    logic [N-1:0]        target;
    logic [IDX_W-1:0]    idx;
    logic                pred;
    logic                pop;
    logic                push;
    logic                room;
    logic                mispred;
    logic                q_full;
    logic                q_empty;
    bpu_entry_t          head;
    bpu_entry_t          tail_entry;
    logic                flush_p1;
    logic [N-1:0]        last_pc_p1;
    logic                q_err_p1;
    logic                unused_bits;

    function automatic ctr_t train(input ctr_t c, input logic taken);
        case (c)
            SNT:     train = taken ? WNT : SNT;
            WNT:     train = taken ? WT  : SNT;
            WT:      train = taken ? ST  : WNT;
            default: train = taken ? ST  : WT;
        endcase
    endfunction

    // Decode/predict: purely combinational against the current IF/DE content.
    always_comb begin
        is_br   = bus.if_valid & (bus.if_instr[31:27] == BR_OPCODE);
        off     = {{(N-17){bus.if_instr[16]}}, bus.if_instr[16:0]};
        pc      = bus.if_pc_inc4 - N'(4);
        target  = pc + $unsigned(off);
        idx     = pc[IDX_W+1:2];
        pred    = (bht[idx] == WT) || (bht[idx] == ST);
        pop     = bus.ex_resolve & ~q_empty;
        mispred = pop & (head.pred != bus.ex_taken);
        // A same-cycle pop frees a slot, so a full queue can still accept.
        room    = ~q_full | pop;
        push    = is_br & ~flush_p1 & room & ~mispred;
    end

    assign tail_entry      = '{pred: pred, target: target, pc_inc4: bus.if_pc_inc4, idx: idx};
    assign bus.BranchTaken = is_br & ~flush_p1 & room & pred;
    assign bus.de_stall    = is_br & ~flush_p1 & ~room;
    assign bus.Flush       = flush_p1;
    assign bus.LastPC      = last_pc_p1;
    assign bus.q_err       = q_err_p1;
    assign unused_bits     = ^{bus.if_instr[26:17], pc[1:0], pc[N-1:IDX_W+2]};

    pred_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (mispred),
        .din   (tail_entry),
        .head  (head),
        .full  (q_full),
        .empty (q_empty)
    );

    // Resolve stage: train the head's counter; a prediction read this cycle sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= WNT;
        end else if (pop) begin
            bht[head.idx] <= train(bht[head.idx], bus.ex_taken);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_p1   <= 1'b0;
            last_pc_p1 <= '0;
            q_err_p1   <= 1'b0;
        end else begin
            flush_p1 <= mispred;
            if (mispred) last_pc_p1 <= bus.ex_taken ? head.target : head.pc_inc4;
            if (bus.ex_resolve && q_empty) q_err_p1 <= 1'b1;
        end
    end

endmodule
